// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: default width,
// FSM state encoding and iteration counter width.
package div_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if non-negative.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_hi,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_hi < dvs on entry, so a non-negative trial always fits in DATA_W bits
  assign shifted  = {rem_hi, bit_in};
  assign diff     = shifted - {1'b0, dvs};
  assign q_bit    = ~diff[DATA_W];
  assign rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, DATA_W cycles per operation.
// Optional macro DIV_EARLY_OUT_EN: skip iteration when y==0 or |x|<|y|.
module div_iter
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              div_clk,
  input  logic              resetn,
  input  logic              div,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] s,
  output logic [DATA_W-1:0] r,
  output logic              complete
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  // Two's-complement negate when en is set; also serves as magnitude.
  function automatic logic [DATA_W-1:0] sign_fix(input logic [DATA_W-1:0] v,
                                                 input logic              en);
    logic signed [DATA_W-1:0] sv;
    sv = $signed(v);
    return en ? DATA_W'(-sv) : v;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dq;
  logic [DATA_W-1:0] dvs;
  logic              qs, rs;

  logic [DATA_W-1:0] ax, ay;
  logic              qs_c, rs_c;
  logic              early;
  logic [DATA_W-1:0] rem_next;
  logic              q_bit;
  logic [DATA_W-1:0] q_final;

  assign ax      = sign_fix(x, div_signed & x[DATA_W-1]);
  assign ay      = sign_fix(y, div_signed & y[DATA_W-1]);
  assign qs_c    = div_signed & (x[DATA_W-1] ^ y[DATA_W-1]);
  assign rs_c    = div_signed & x[DATA_W-1];
  assign q_final = {dq[DATA_W-2:0], q_bit};

`ifdef DIV_EARLY_OUT_EN
  logic [DATA_W-1:0] q_early;
  assign early   = (y == '0) || (ax < ay);
  assign q_early = (y == '0) ? '1 : '0;
`else
  assign early = 1'b0;
`endif

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_hi   (rem),
    .bit_in   (dq[DATA_W-1]),
    .dvs      (dvs),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (div) state_nxt = early ? DONE : BUSY;
      BUSY: begin
        if (!div)             state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      cnt      <= '0;
      rem      <= '0;
      dq       <= '0;
      dvs      <= '0;
      qs       <= 1'b0;
      rs       <= 1'b0;
      s        <= '0;
      r        <= '0;
      complete <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (state == IDLE && div) begin
        dvs <= ay;
        dq  <= ax;
        rem <= '0;
        cnt <= '0;
        qs  <= qs_c;
        rs  <= rs_c;
`ifdef DIV_EARLY_OUT_EN
        if (early) begin
          s        <= sign_fix(q_early, qs_c);
          r        <= sign_fix(ax, rs_c);
          complete <= 1'b1;
        end
`endif
      end else if (state == BUSY && div) begin
        rem <= rem_next;
        dq  <= q_final;
        cnt <= cnt + CNT_W'(1);
        // Result is registered on the edge that enters DONE
        if (cnt == LAST) begin
          s        <= sign_fix(q_final, qs);
          r        <= sign_fix(rem_next, rs);
          complete <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: latency, signed/unsigned results,
// divide-by-zero, back-to-back, abort and asynchronous reset.
module tb_div_iter;

  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_E = 1;
`else
  localparam int LAT_E = 33;
`endif

  logic         div_clk = 1'b0;
  logic         resetn;
  logic         div;
  logic         div_signed;
  logic [W-1:0] x, y;
  logic [W-1:0] s, r;
  logic         complete;

  int errors = 0;
  int checks = 0;

  div_iter #(.DATA_W(W)) dut (
    .div_clk    (div_clk),
    .resetn     (resetn),
    .div        (div),
    .div_signed (div_signed),
    .x          (x),
    .y          (y),
    .s          (s),
    .r          (r),
    .complete   (complete)
  );

  always #5 div_clk = ~div_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  // Count cycles until complete is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!complete && n < 200);
  endtask

  task automatic run_div(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                         input logic sg, input logic [31:0] es, input logic [31:0] er,
                         input int lat);
    int n;
    x = xv; y = yv; div_signed = sg; div = 1'b1;
    wait_done(n);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_s"}, s, es);
    chk({tag, "_r"}, r, er);
    div = 1'b0;
    tick();
    chk({tag, "_pulse"}, {31'b0, complete}, 32'd0);
  endtask

  initial begin
    int n;
    int seen;
    resetn = 1'b0; div = 1'b0; div_signed = 1'b0; x = '0; y = '0;
    tick(); tick();
    chk("rst_s", s, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_cmp", {31'b0, complete}, 32'd0);
    resetn = 1'b1;
    tick();

    run_div("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33);
    run_div("s-7_2",    32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   33);
    run_div("s7_-2",    32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          33);
    run_div("smin_m1",  32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          33);
    run_div("umin_max", 32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   LAT_E);
    run_div("u5_0",     32'd5,          32'd0,          1'b0, 32'hFFFFFFFF,   32'd5,          LAT_E);
    run_div("s-5_0",    32'hFFFFFFFB,   32'd0,          1'b1, 32'd1,          32'hFFFFFFFB,   LAT_E);
    run_div("u3_10",    32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          LAT_E);

    // Back-to-back: div held, operands swapped in the IDLE cycle after DONE
    x = 32'd20; y = 32'd3; div_signed = 1'b0; div = 1'b1;
    wait_done(n);
    chk("b2b1_lat", n, 33);
    chk("b2b1_s", s, 32'd6);
    chk("b2b1_r", r, 32'd2);
    tick();
    chk("b2b_gap", {31'b0, complete}, 32'd0);
    x = 32'd9; y = 32'd4;
    wait_done(n);
    chk("b2b2_lat", n, 33);
    chk("b2b2_s", s, 32'd2);
    chk("b2b2_r", r, 32'd1);
    div = 1'b0;
    tick();
    chk("b2b2_pulse", {31'b0, complete}, 32'd0);

    // Abort at cycle 10: no completion, outputs hold
    x = 32'd50; y = 32'd5; div = 1'b1;
    repeat (10) tick();
    div = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (complete) seen++;
    end
    chk("abort_cmp", seen, 0);
    chk("abort_s", s, 32'd2);
    chk("abort_r", r, 32'd1);
    run_div("post_abort", 32'd15, 32'd4, 1'b0, 32'd3, 32'd3, 33);

    // Asynchronous reset at cycle 15
    x = 32'd100; y = 32'd7; div = 1'b1;
    repeat (15) tick();
    resetn = 1'b0; div = 1'b0;
    #1;
    chk("mrst_s", s, 32'd0);
    chk("mrst_r", r, 32'd0);
    chk("mrst_cmp", {31'b0, complete}, 32'd0);
    #2 resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      tick();
      if (complete) seen++;
    end
    chk("mrst_nocmp", seen, 0);
    run_div("post_rst", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
